// File: rtl/reset_seq.sv
// Staged reset sequencer: synchronised power-on hold, per-channel staggered release, soft restart.
// Define RESET_SEQ_WDT_EN to compile in the RUN-state watchdog (cause 2 on expiry).

module reset_seq_checker #(
    parameter int CHANNELS = 2
) (
    input logic                clk,
    input logic                rst_n,
    input logic [CHANNELS-1:0] reset,
    input logic                ready,
    input logic [1:0]          cause
);
    a_ready_clean: assert property (@(posedge clk) disable iff (!rst_n)
        ready |-> (reset == {CHANNELS{1'b0}}));

    a_cause_legal: assert property (@(posedge clk) disable iff (!rst_n)
        cause != 2'd3);

`ifndef RESET_SEQ_WDT_EN
    a_no_wdt_cause: assert property (@(posedge clk) disable iff (!rst_n)
        cause != 2'd2);
`endif

    // A higher channel may only be out of reset once every lower channel is.
    for (genvar k = 1; k < CHANNELS; k++) begin : g_order
        a_release_order: assert property (@(posedge clk) disable iff (!rst_n)
            !reset[k] |-> !reset[k-1]);
    end
endmodule

module reset_seq #(
    parameter int RESET_TIMER_BIT = 24,
    parameter int CHANNELS        = 2,
    parameter int STAGE_GAP_BIT   = 4,
    parameter int WDT_BIT         = 24
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                soft_req,
    input  logic                wdt_kick,
    output logic [CHANNELS-1:0] reset,
    output logic                ready,
    output logic [1:0]          cause
);
    localparam int         HW         = RESET_TIMER_BIT + 1;
    localparam int         GW         = STAGE_GAP_BIT + 1;
    localparam logic [2:0] CH_LAST    = 3'(CHANNELS - 1);
    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_SOFT = 2'd1;
    localparam logic [1:0] CAUSE_WDT  = 2'd2;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_COUNT = 2'd1,
        S_STAGE = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic                sync1_r, sync2_r;
    logic [HW-1:0]       hold_cnt_r, hold_cnt_s, hold_inc_s;
    logic [GW-1:0]       gap_cnt_r, gap_cnt_s, gap_inc_s;
    logic [2:0]          chan_r, chan_s;
    logic [CHANNELS-1:0] reset_r, reset_s;
    logic                ready_r, ready_s;
    logic [1:0]          cause_r, cause_s;
    logic                restart_s;
    logic [1:0]          restart_cause_s;
    logic                wdt_expire_s;

    assign hold_inc_s = hold_cnt_r + HW'(1'b1);
    assign gap_inc_s  = gap_cnt_r + GW'(1'b1);

    // Two-flop synchroniser for the asynchronous reset release.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= 1'b1;
            sync2_r <= sync1_r;
        end
    end

`ifdef RESET_SEQ_WDT_EN
    localparam int WW = WDT_BIT + 1;
    logic [WW-1:0] wdt_cnt_r, wdt_cnt_s, wdt_inc_s;

    assign wdt_inc_s    = wdt_cnt_r + WW'(1'b1);
    // A kick on the would-be expiry edge takes priority over the timeout.
    assign wdt_expire_s = (state_r == S_RUN) && wdt_inc_s[WDT_BIT] && !wdt_kick;

    // Watchdog counter next value: runs only in RUN, idle at zero elsewhere.
    always_comb begin
        wdt_cnt_s = {WW{1'b0}};
        if ((state_r == S_RUN) && !restart_s) begin
            if (wdt_kick) begin
                wdt_cnt_s = {WW{1'b0}};
            end else begin
                wdt_cnt_s = wdt_inc_s;
            end
        end else begin
            wdt_cnt_s = {WW{1'b0}};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wdt_cnt_r <= {WW{1'b0}};
        end else begin
            wdt_cnt_r <= wdt_cnt_s;
        end
    end
`else
    logic unused_kick_s;

    assign unused_kick_s = wdt_kick;
    assign wdt_expire_s  = 1'b0;
`endif

    // Restart request in RUN; software request beats a simultaneous watchdog expiry.
    always_comb begin
        restart_s       = 1'b0;
        restart_cause_s = CAUSE_SOFT;
        if ((state_r == S_RUN) && soft_req) begin
            restart_s       = 1'b1;
            restart_cause_s = CAUSE_SOFT;
        end else if (wdt_expire_s) begin
            restart_s       = 1'b1;
            restart_cause_s = CAUSE_WDT;
        end else begin
            restart_s       = 1'b0;
            restart_cause_s = CAUSE_SOFT;
        end
    end

    // Sequencer next-state, counters and output values.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        chan_s     = chan_r;
        reset_s    = reset_r;
        ready_s    = ready_r;
        cause_s    = cause_r;
        case (state_r)
            S_HOLD: begin
                hold_cnt_s = {HW{1'b0}};
                // Leave on the edge that raises the synchronised release.
                if (sync1_r && !sync2_r) begin
                    state_s = S_COUNT;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_COUNT: begin
                hold_cnt_s = hold_inc_s;
                if (hold_inc_s[RESET_TIMER_BIT]) begin
                    hold_cnt_s = {HW{1'b0}};
                    gap_cnt_s  = {GW{1'b0}};
                    chan_s     = 3'd1;
                    reset_s    = reset_r & ~CHANNELS'(1'b1);
                    if (CHANNELS == 1) begin
                        state_s = S_RUN;
                        ready_s = 1'b1;
                    end else begin
                        state_s = S_STAGE;
                    end
                end else begin
                    state_s = S_COUNT;
                end
            end
            S_STAGE: begin
                gap_cnt_s = gap_inc_s;
                if (gap_inc_s[STAGE_GAP_BIT]) begin
                    gap_cnt_s = {GW{1'b0}};
                    reset_s   = reset_r & ~(CHANNELS'(1'b1) << chan_r);
                    if (chan_r == CH_LAST) begin
                        state_s = S_RUN;
                        ready_s = 1'b1;
                    end else begin
                        chan_s  = chan_r + 3'd1;
                        state_s = S_STAGE;
                    end
                end else begin
                    state_s = S_STAGE;
                end
            end
            S_RUN: begin
                if (restart_s) begin
                    state_s    = S_COUNT;
                    reset_s    = {CHANNELS{1'b1}};
                    ready_s    = 1'b0;
                    cause_s    = restart_cause_s;
                    hold_cnt_s = {HW{1'b0}};
                    gap_cnt_s  = {GW{1'b0}};
                    chan_s     = 3'd0;
                end else begin
                    state_s = S_RUN;
                end
            end
            default: begin
                state_s = S_HOLD;
            end
        endcase
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= S_HOLD;
            hold_cnt_r <= {HW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            chan_r     <= 3'd0;
            reset_r    <= {CHANNELS{1'b1}};
            ready_r    <= 1'b0;
            cause_r    <= CAUSE_POR;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            chan_r     <= chan_s;
            reset_r    <= reset_s;
            ready_r    <= ready_s;
            cause_r    <= cause_s;
        end
    end

    assign reset = reset_r;
    assign ready = ready_r;
    assign cause = cause_r;

    reset_seq_checker #(
        .CHANNELS (CHANNELS)
    ) u_checker (
        .clk   (CLK),
        .rst_n (RESET_N),
        .reset (reset_r),
        .ready (ready_r),
        .cause (cause_r)
    );
endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: a 3-channel and a 1-channel instance share one output monitor.
// Every change of the combined outputs must match the next queued (cycle, value) event.

module tb_reset_seq;
    typedef struct {
        int         cyc;
        logic [9:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst3 = 1'b1;
    logic       rst1 = 1'b1;
    logic       soft3 = 1'b0;
    logic       soft1 = 1'b0;
    logic       kick3 = 1'b0;
    logic       kick1 = 1'b0;
    logic [2:0] reset3;
    logic       ready3;
    logic [1:0] cause3;
    logic [0:0] reset1;
    logic       ready1;
    logic [1:0] cause1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 1'b0;
    ev_t  exp_q[$];

    logic [2:0] m_r3 = 3'b111;
    logic       m_rdy3 = 1'b0;
    logic [1:0] m_c3 = 2'd0;
    logic       m_r1 = 1'b1;
    logic       m_rdy1 = 1'b0;
    logic [1:0] m_c1 = 2'd0;

    reset_seq #(
        .RESET_TIMER_BIT (4),
        .CHANNELS        (3),
        .STAGE_GAP_BIT   (2),
        .WDT_BIT         (5)
    ) dut (
        .CLK      (clk),
        .RESET_N  (rst3),
        .soft_req (soft3),
        .wdt_kick (kick3),
        .reset    (reset3),
        .ready    (ready3),
        .cause    (cause3)
    );

    reset_seq #(
        .RESET_TIMER_BIT (4),
        .CHANNELS        (1),
        .STAGE_GAP_BIT   (2),
        .WDT_BIT         (5)
    ) dut1 (
        .CLK      (clk),
        .RESET_N  (rst1),
        .soft_req (soft1),
        .wdt_kick (kick1),
        .reset    (reset1),
        .ready    (ready1),
        .cause    (cause1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect3(input int at, input logic [2:0] r, input logic rdy, input logic [1:0] c);
        m_r3 = r;
        m_rdy3 = rdy;
        m_c3 = c;
        exp_q.push_back('{cyc: at, val: {m_r3, m_rdy3, m_c3, m_r1, m_rdy1, m_c1}});
    endtask

    task automatic expect1(input int at, input logic r, input logic rdy, input logic [1:0] c);
        m_r1 = r;
        m_rdy1 = rdy;
        m_c1 = c;
        exp_q.push_back('{cyc: at, val: {m_r3, m_rdy3, m_c3, m_r1, m_rdy1, m_c1}});
    endtask

    // Stimulus: each step queues the output changes it must cause.
    initial begin : stim
        int r;
        int s;
        int q;
        expect3(0, 3'b111, 1'b0, 2'd0);
        #1 rst3 = 1'b0;
        rst1 = 1'b0;

        // power-on release of the 3-channel instance
        tick(3);
        rst3 = 1'b1;
        r = cyc;
        expect3(r + 18, 3'b110, 1'b0, 2'd0);
        expect3(r + 22, 3'b100, 1'b0, 2'd0);
        expect3(r + 26, 3'b000, 1'b1, 2'd0);
        tick(28);

        // single-cycle soft request in RUN
        s = cyc;
        soft3 = 1'b1;
        expect3(s + 1,  3'b111, 1'b0, 2'd1);
        expect3(s + 17, 3'b110, 1'b0, 2'd1);
        expect3(s + 21, 3'b100, 1'b0, 2'd1);
        expect3(s + 25, 3'b000, 1'b1, 2'd1);
        tick(1);
        soft3 = 1'b0;
        tick(26);

        // soft request held through COUNT/STAGE: ignored until the next RUN edge
        s = cyc;
        soft3 = 1'b1;
        expect3(s + 1,  3'b111, 1'b0, 2'd1);
        expect3(s + 17, 3'b110, 1'b0, 2'd1);
        expect3(s + 21, 3'b100, 1'b0, 2'd1);
        expect3(s + 25, 3'b000, 1'b1, 2'd1);
        expect3(s + 26, 3'b111, 1'b0, 2'd1);
        expect3(s + 42, 3'b110, 1'b0, 2'd1);
        expect3(s + 46, 3'b100, 1'b0, 2'd1);
        expect3(s + 50, 3'b000, 1'b1, 2'd1);
        tick(26);
        soft3 = 1'b0;
        tick(24);

        // asynchronous reset mid-STAGE, then a full restart
        s = cyc;
        soft3 = 1'b1;
        expect3(s + 1,  3'b111, 1'b0, 2'd1);
        expect3(s + 17, 3'b110, 1'b0, 2'd1);
        tick(1);
        soft3 = 1'b0;
        tick(18);
        expect3(s + 19, 3'b111, 1'b0, 2'd0);
        rst3 = 1'b0;
        tick(2);
        rst3 = 1'b1;
        r = cyc;
        expect3(r + 18, 3'b110, 1'b0, 2'd0);
        expect3(r + 22, 3'b100, 1'b0, 2'd0);
        expect3(r + 26, 3'b000, 1'b1, 2'd0);
        tick(26);

`ifdef RESET_SEQ_WDT_EN
        // regular kicks keep the watchdog quiet
        for (int i = 0; i < 5; i++) begin
            tick(19);
            kick3 = 1'b1;
            tick(1);
            kick3 = 1'b0;
        end
        // kick exactly on the expiry edge
        tick(31);
        kick3 = 1'b1;
        tick(1);
        kick3 = 1'b0;
        // soft request on the expiry edge wins
        q = cyc;
        tick(31);
        soft3 = 1'b1;
        expect3(q + 32, 3'b111, 1'b0, 2'd1);
        expect3(q + 48, 3'b110, 1'b0, 2'd1);
        expect3(q + 52, 3'b100, 1'b0, 2'd1);
        expect3(q + 56, 3'b000, 1'b1, 2'd1);
        tick(1);
        soft3 = 1'b0;
        tick(24);
        // unserviced watchdog expires on the 32nd RUN cycle
        q = cyc;
        expect3(q + 32, 3'b111, 1'b0, 2'd2);
        expect3(q + 48, 3'b110, 1'b0, 2'd2);
        expect3(q + 52, 3'b100, 1'b0, 2'd2);
        expect3(q + 56, 3'b000, 1'b1, 2'd2);
        tick(56);
`else
        tick(100);
`endif

        // park the 3-channel instance and exercise the single-channel one
        q = cyc;
        expect3(q, 3'b111, 1'b0, 2'd0);
        rst3 = 1'b0;
        tick(2);
        rst1 = 1'b1;
        r = cyc;
        expect1(r + 18, 1'b0, 1'b1, 2'd0);
        tick(20);
        s = cyc;
        soft1 = 1'b1;
        expect1(s + 1,  1'b1, 1'b0, 2'd1);
        expect1(s + 17, 1'b0, 1'b1, 2'd1);
        tick(1);
        soft1 = 1'b0;
        tick(16);
`ifdef RESET_SEQ_WDT_EN
        q = cyc;
        expect1(q + 32, 1'b1, 1'b0, 2'd2);
        expect1(q + 48, 1'b0, 1'b1, 2'd2);
        tick(50);
`else
        tick(100);
`endif
        tick(3);
        stim_done = 1'b1;
    end

    // Monitor: any output change pops and checks the next expected event.
    initial begin : monitor
        logic [9:0] cur;
        logic [9:0] prev;
        bit         first;
        ev_t        e;
        first = 1'b1;
        prev  = 10'd0;
        forever begin
            @(negedge clk or negedge rst3);
            #1;
            cur = {reset3, ready3, cause3, reset1, ready1, cause1};
            if (first || (cur !== prev)) begin
                first = 1'b0;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.cyc != cyc) || (e.val !== cur)) begin
                        n_bad++;
                        $display("FAIL output_event got cyc=%0d val=%b required cyc=%0d val=%b",
                                 cyc, cur, e.cyc, e.val);
                    end
                end
                prev = cur;
            end
            if (stim_done) begin
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_event got=none required cyc=%0d val=%b", e.cyc, e.val);
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    // Hard time limit so the run can never hang.
    initial begin : timeout
        #200000;
        $display("FAIL timeout got=running required=finished by t=200000");
        $fatal(1, "time limit");
    end
endmodule
